sobel_gradient_pipe: RTL and testbench

Parametrised, pipelined Sobel gradient engine: accepts one 3x3 pixel window per cycle over a valid/ready handshake and produces the horizontal gradient gx, the vertical gradient gy, a saturated magnitude, an edge flag and a running edge count. It sits between the window line-buffer and the edge-map writer, and is the streaming, stallable, multi-mode generation of the vertical-gradient unit.

---
 rtl/sobel_gradient_pipe.sv | 208 ++++++++++++++++++++
 tb/tb_sobel_gradient_pipe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_gradient_pipe.sv
// Sobel gradient engine: takes one 3x3 window per cycle over valid/ready and
// produces gx, gy, a saturated |gx|+|gy| magnitude, an edge flag and a
// saturating count of accepted edge results.
// The edge flag output is named edge_o because "edge" is a reserved word.
// Three register stages share one global stall: every stage advances when the
// last stage is empty or the consumer accepts.
module sobel_gradient_pipe #(
  parameter int PIXEL_W = 8,
  parameter int MODE    = 0,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [PIXEL_W-1:0]        p0,
  input  logic [PIXEL_W-1:0]        p1,
  input  logic [PIXEL_W-1:0]        p2,
  input  logic [PIXEL_W-1:0]        p3,
  input  logic [PIXEL_W-1:0]        p4,
  input  logic [PIXEL_W-1:0]        p5,
  input  logic [PIXEL_W-1:0]        p6,
  input  logic [PIXEL_W-1:0]        p7,
  input  logic [PIXEL_W-1:0]        p8,
  input  logic [PIXEL_W-1:0]        threshold,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [PIXEL_W+2:0] gx,
  output logic signed [PIXEL_W+2:0] gy,
  output logic [PIXEL_W-1:0]        mag,
  output logic                      edge_o,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          edge_cnt
);

  localparam int SW = PIXEL_W + 2;  // weighted row/column sum, max 4*(2^W-1)
  localparam int GW = PIXEL_W + 3;  // signed gradient
  localparam int MW = PIXEL_W + 4;  // |gx|+|gy|

  localparam logic [MW-1:0]    MAG_MAX = MW'({PIXEL_W{1'b1}});
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // a + 2b + c with room for the largest possible result
  function automatic logic [SW-1:0] wsum(input logic [PIXEL_W-1:0] a,
                                         input logic [PIXEL_W-1:0] b,
                                         input logic [PIXEL_W-1:0] c);
    return SW'(a) + (SW'(b) << 1) + SW'(c);
  endfunction

  // Absolute value widened by one bit; magnitude never exceeds 2^(GW-1)-1
  function automatic logic [MW-1:0] mag_abs(input logic signed [GW-1:0] v);
    logic [GW-1:0] u;
    if (v[GW-1]) begin
      u = -v;
    end else begin
      u = v;
    end
    return {1'b0, u};
  endfunction

  logic            advance_s;
  logic            v1_q, v2_q, v3_q;

  logic [SW-1:0]   rs_top_d, rs_bot_d, cs_left_d, cs_right_d;
  logic [SW-1:0]   rs_top_q, rs_bot_q, cs_left_q, cs_right_q;
  logic [PIXEL_W-1:0] thr1_d, thr1_q;

  logic signed [GW-1:0] gx_full_s, gy_full_s;
  logic signed [GW-1:0] gx2_d, gy2_d, gx2_q, gy2_q;
  logic [PIXEL_W-1:0]   thr2_d, thr2_q;

  logic [MW-1:0]        sum_s;
  logic signed [GW-1:0] gx3_d, gy3_d, gx3_q, gy3_q;
  logic [PIXEL_W-1:0]   mag3_d, mag3_q;
  logic                 edge3_d, edge3_q;

  logic [CNT_W-1:0]     cnt_d, cnt_q;

  assign advance_s = !v3_q | out_ready;
  assign in_ready  = advance_s;
  assign out_valid = v3_q;
  assign gx        = gx3_q;
  assign gy        = gy3_q;
  assign mag       = mag3_q;
  assign edge_o    = edge3_q;
  assign edge_cnt  = cnt_q;

  // Stage valid bits: all stages move together on advance, hold otherwise
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (advance_s) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  // S1 next state: weighted row and column partial sums
  always_comb begin
    rs_top_d   = wsum(p0, p1, p2);
    rs_bot_d   = wsum(p6, p7, p8);
    cs_left_d  = wsum(p0, p3, p6);
    cs_right_d = wsum(p2, p5, p8);
    thr1_d     = threshold;
  end

  // S1 registers: load only when a window is actually taken in
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rs_top_q   <= '0;
      rs_bot_q   <= '0;
      cs_left_q  <= '0;
      cs_right_q <= '0;
      thr1_q     <= '0;
    end else if (advance_s && in_valid) begin
      rs_top_q   <= rs_top_d;
      rs_bot_q   <= rs_bot_d;
      cs_left_q  <= cs_left_d;
      cs_right_q <= cs_right_d;
      thr1_q     <= thr1_d;
    end
  end

  // S2 next state: signed differences, then zero the gradient MODE disables
  always_comb begin
    gx_full_s = $signed({1'b0, cs_right_q}) - $signed({1'b0, cs_left_q});
    gy_full_s = $signed({1'b0, rs_top_q}) - $signed({1'b0, rs_bot_q});
    if (MODE == 32'sd1) begin
      gx2_d = '0;
    end else begin
      gx2_d = gx_full_s;
    end
    if (MODE == 32'sd2) begin
      gy2_d = '0;
    end else begin
      gy2_d = gy_full_s;
    end
    thr2_d = thr1_q;
  end

  // S2 registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      gx2_q  <= '0;
      gy2_q  <= '0;
      thr2_q <= '0;
    end else if (advance_s && v1_q) begin
      gx2_q  <= gx2_d;
      gy2_q  <= gy2_d;
      thr2_q <= thr2_d;
    end
  end

  // S3 next state: clamped magnitude and threshold compare
  always_comb begin
    gx3_d = gx2_q;
    gy3_d = gy2_q;
    sum_s = mag_abs(gx2_q) + mag_abs(gy2_q);
    if (sum_s > MAG_MAX) begin
      mag3_d = {PIXEL_W{1'b1}};
    end else begin
      mag3_d = sum_s[PIXEL_W-1:0];
    end
    edge3_d = (mag3_d >= thr2_q);
  end

  // S3 registers drive the outputs; loading only on a valid S2 keeps the
  // last result visible while out_valid is low
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      gx3_q   <= '0;
      gy3_q   <= '0;
      mag3_q  <= '0;
      edge3_q <= 1'b0;
    end else if (advance_s && v2_q) begin
      gx3_q   <= gx3_d;
      gy3_q   <= gy3_d;
      mag3_q  <= mag3_d;
      edge3_q <= edge3_d;
    end
  end

  // Edge counter next state: clear wins, otherwise saturating increment on
  // an accepted edge result
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (v3_q && out_ready && edge3_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Edge counter register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sobel_gradient_pipe.sv
// Directed bench for sobel_gradient_pipe. dut_a: MODE=0, CNT_W=2 (exercises
// counter saturation). dut_b: MODE=2, CNT_W=16, sharing the same inputs.
module tb_sobel_gradient_pipe;

  logic       clk;
  logic       n_rst;
  logic [7:0] pix [9];
  logic [7:0] thr;
  logic       in_valid;
  logic       out_ready;
  logic       cnt_clr;

  logic              a_in_ready, a_out_valid, a_edge;
  logic signed [10:0] a_gx, a_gy;
  logic [7:0]        a_mag;
  logic [1:0]        a_cnt;

  logic              b_in_ready, b_out_valid, b_edge;
  logic signed [10:0] b_gx, b_gy;
  logic [7:0]        b_mag;
  logic [15:0]       b_cnt;

  int checks;
  int failures;

  sobel_gradient_pipe #(.PIXEL_W(8), .MODE(0), .CNT_W(2)) dut_a (
    .clk(clk), .n_rst(n_rst),
    .p0(pix[0]), .p1(pix[1]), .p2(pix[2]), .p3(pix[3]), .p4(pix[4]),
    .p5(pix[5]), .p6(pix[6]), .p7(pix[7]), .p8(pix[8]),
    .threshold(thr), .in_valid(in_valid), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .gx(a_gx), .gy(a_gy), .mag(a_mag), .edge_o(a_edge),
    .cnt_clr(cnt_clr), .edge_cnt(a_cnt)
  );

  sobel_gradient_pipe #(.PIXEL_W(8), .MODE(2), .CNT_W(16)) dut_b (
    .clk(clk), .n_rst(n_rst),
    .p0(pix[0]), .p1(pix[1]), .p2(pix[2]), .p3(pix[3]), .p4(pix[4]),
    .p5(pix[5]), .p6(pix[6]), .p7(pix[7]), .p8(pix[8]),
    .threshold(thr), .in_valid(in_valid), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .gx(b_gx), .gy(b_gy), .mag(b_mag), .edge_o(b_edge),
    .cnt_clr(cnt_clr), .edge_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_win(input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2, input logic [7:0] a3,
                         input logic [7:0] a4, input logic [7:0] a5,
                         input logic [7:0] a6, input logic [7:0] a7,
                         input logic [7:0] a8, input logic [7:0] t);
    pix[0] = a0; pix[1] = a1; pix[2] = a2;
    pix[3] = a3; pix[4] = a4; pix[5] = a5;
    pix[6] = a6; pix[7] = a7; pix[8] = a8;
    thr = t;
  endtask

  // Right column = 10*k, rest 0: gx = 40*k, gy = 0, never an edge at thr 255
  task automatic set_ramp(input int k);
    logic [7:0] v;
    v = 8'(10 * k);
    set_win(8'd0, 8'd0, v, 8'd0, 8'd0, v, 8'd0, 8'd0, v, 8'd255);
  endtask

  // Present the current window for one edge, then wait until it reaches S3
  task automatic send_one();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_edge1_valid", a_out_valid, 0);
    tick();
    chk("lat_edge2_valid", a_out_valid, 0);
    tick();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    n_rst     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    set_win(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);

    // Reset state
    #2;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_gx", a_gx, 0);
    chk("rst_gy", a_gy, 0);
    chk("rst_mag", a_mag, 0);
    chk("rst_edge", a_edge, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_in_ready", a_in_ready, 1);
    #1 n_rst = 1'b1;

    // Horizontal edge
    set_win(8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd128);
    send_one();
    chk("hedge_valid", a_out_valid, 1);
    chk("hedge_gx", a_gx, 0);
    chk("hedge_gy", a_gy, 1020);
    chk("hedge_mag", a_mag, 255);
    chk("hedge_edge", a_edge, 1);
    chk("hedge_cnt_before", a_cnt, 0);
    chk("hedge_b_gy", b_gy, 0);
    chk("hedge_b_mag", b_mag, 0);
    chk("hedge_b_edge", b_edge, 0);
    tick();
    chk("hedge_cnt_after", a_cnt, 1);
    chk("hedge_valid_drop", a_out_valid, 0);
    chk("hedge_gy_hold", a_gy, 1020);

    // Small vertical step
    set_win(8'd0, 8'd5, 8'd10, 8'd0, 8'd5, 8'd10, 8'd0, 8'd5, 8'd10, 8'd50);
    send_one();
    chk("vstep_valid", a_out_valid, 1);
    chk("vstep_gx", a_gx, 40);
    chk("vstep_gy", a_gy, 0);
    chk("vstep_mag", a_mag, 40);
    chk("vstep_edge", a_edge, 0);
    chk("vstep_b_gx", b_gx, 40);
    chk("vstep_b_mag", b_mag, 40);
    tick();
    chk("vstep_cnt", a_cnt, 1);

    // Negative gy, threshold 0; MODE=2 zeroes gy
    set_win(8'd0, 8'd0, 8'd0, 8'd10, 8'd10, 8'd10, 8'd20, 8'd20, 8'd20, 8'd0);
    send_one();
    chk("neg_gx", a_gx, 0);
    chk("neg_gy", a_gy, -80);
    chk("neg_mag", a_mag, 80);
    chk("neg_edge", a_edge, 1);
    chk("neg_b_gx", b_gx, 0);
    chk("neg_b_gy", b_gy, 0);
    chk("neg_b_mag", b_mag, 0);
    chk("neg_b_edge", b_edge, 1);
    tick();
    chk("neg_cnt", a_cnt, 2);

    // Backpressure: 6 cycles of out_ready=0 with windows offered every cycle
    out_ready = 1'b0;
    begin
      int idx;
      idx = 1;
      for (int c = 0; c < 6; c++) begin
        set_ramp(idx);
        in_valid = 1'b1;
        #1;
        chk("bp_in_ready", a_in_ready, (c < 3) ? 1 : 0);
        if (c >= 3) begin
          chk("bp_hold_valid", a_out_valid, 1);
          chk("bp_hold_gx", a_gx, 40);
        end
        tick();
        if (c < 3) idx++;
      end
      chk("bp_accepted", idx, 4);
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      if (k == 1) begin
        set_ramp(4);
        in_valid = 1'b1;
      end else if (k == 2) begin
        set_ramp(5);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("drain_valid", a_out_valid, 1);
      chk("drain_gx", a_gx, 40 * k);
      chk("drain_in_ready", a_in_ready, 1);
      tick();
    end
    chk("drain_empty", a_out_valid, 0);
    chk("drain_gx_hold", a_gx, 200);
    chk("drain_cnt", a_cnt, 2);

    // Counter saturation with CNT_W=2
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_cnt", a_cnt, 0);
    set_win(8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd128);
    for (int c = 1; c <= 8; c++) begin
      in_valid = (c <= 5);
      tick();
      chk("sat_cnt", a_cnt, (c < 4) ? 0 : ((c - 3 > 3) ? 3 : c - 3));
    end
    in_valid = 1'b0;
    chk("sat_empty", a_out_valid, 0);

    // Reset with two windows in flight
    set_win(8'd0, 8'd0, 8'd0, 8'd10, 8'd10, 8'd10, 8'd20, 8'd20, 8'd20, 8'd0);
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    chk("mrst_valid", a_out_valid, 0);
    chk("mrst_gx", a_gx, 0);
    chk("mrst_gy", a_gy, 0);
    chk("mrst_mag", a_mag, 0);
    chk("mrst_edge", a_edge, 0);
    chk("mrst_cnt", a_cnt, 0);
    chk("mrst_in_ready", a_in_ready, 1);
    #1 n_rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("mrst_no_stale", a_out_valid, 0);
    end
    chk("mrst_gy_after", a_gy, 0);

    // cnt_clr coincident with an edge transfer, then a normal count
    set_win(8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd128);
    send_one();
    chk("cc_valid", a_out_valid, 1);
    chk("cc_edge", a_edge, 1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cc_cnt", a_cnt, 0);
    chk("cc_consumed", a_out_valid, 0);
    send_one();
    tick();
    chk("post_cc_cnt", a_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
